// File: rtl/vip_clock_pkg.sv
// Shared types and helpers for the clock VIP generator channels.
// Purely combinational definitions; no latency or flow control of its own.
package vip_clock_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } clk_gen_state_e;

  localparam int MIN_DIV = 2;

  // Odd ratios put the extra cycle in the high phase.
  function automatic int unsigned hi_phase_len(input int unsigned ratio);
    return ratio - (ratio >> 1);
  endfunction

endpackage

// File: rtl/vip_clock_gen_ch.sv
// One generated clock channel: FSM, phase counter, shadowed ratio, sticky error.
// Latency: o_clk rises 1 cycle after i_en is sampled; no backpressure, phases never truncated.
module vip_clock_gen_ch
  import vip_clock_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div_ratio,
  input  logic             i_div_load,
  output logic             o_clk,
  output logic             o_running,
  output logic             o_cfg_err
);

  clk_gen_state_e   r_state;
  clk_gen_state_e   w_state_nxt;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic [DIV_W-1:0] r_active;
  logic [DIV_W-1:0] w_active_nxt;
  logic [DIV_W-1:0] r_shadow;
  logic             r_clk_q;
  logic             w_clk_nxt;
  logic             r_cfg_err;
  logic             w_cnt_zero;
  logic [DIV_W-1:0] w_hi_m1_shadow;
  logic [DIV_W-1:0] w_lo_m1_active;

  // Counter holds remaining cycles of the current phase minus one.
  assign w_cnt_zero     = (r_cnt == '0);
  assign w_hi_m1_shadow = DIV_W'(hi_phase_len(32'(r_shadow)) - 32'd1);
  assign w_lo_m1_active = (r_active >> 1) - DIV_W'(1);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_clk_nxt    = r_clk_q;
    w_active_nxt = r_active;
    case (r_state)
      IDLE: begin
        if (i_en) begin
          w_state_nxt  = RUN;
          w_clk_nxt    = 1'b1;
          w_active_nxt = r_shadow;
          w_cnt_nxt    = w_hi_m1_shadow;
        end
      end
      RUN, STOPPING: begin
        if (r_clk_q || !w_cnt_zero) begin
          w_state_nxt = i_en ? RUN : STOPPING;
          if (!w_cnt_zero) begin
            w_cnt_nxt = r_cnt - DIV_W'(1);
          end else begin
            w_clk_nxt = 1'b0;
            w_cnt_nxt = w_lo_m1_active;
          end
        end else begin
          // Period boundary: the ratio change and the stop decision happen only here.
          w_active_nxt = r_shadow;
          if (i_en) begin
            w_state_nxt = RUN;
            w_clk_nxt   = 1'b1;
            w_cnt_nxt   = w_hi_m1_shadow;
          end else begin
            w_state_nxt = IDLE;
            w_clk_nxt   = 1'b0;
            w_cnt_nxt   = '0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_clk_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_clk_q   <= 1'b0;
      r_active  <= DIV_W'(DEFAULT_DIV);
      r_shadow  <= DIV_W'(DEFAULT_DIV);
      r_cfg_err <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_clk_q  <= w_clk_nxt;
      r_active <= w_active_nxt;
      if (i_div_load) begin
        if (i_div_ratio < DIV_W'(MIN_DIV)) begin
          r_cfg_err <= 1'b1;
        end else begin
          r_shadow <= i_div_ratio;
        end
      end
    end
  end

  assign o_clk     = r_clk_q;
  assign o_running = (r_state != IDLE);
  assign o_cfg_err = r_cfg_err;

endmodule

// File: rtl/vip_clock_gen.sv
// Multi-channel clock generator for the clock VIP; outputs float when the agent is passive.
// Latency: each clk_out rises 1 cycle after its ch_en is sampled; no backpressure.
module vip_clock_gen
  import vip_clock_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    agent_is_active,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*DIV_W-1:0] div_ratio,
  input  logic [NUM_CH-1:0]       div_load,
  output wire  [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       clk_running,
  output logic [NUM_CH-1:0]       cfg_err
);

  logic [NUM_CH-1:0] w_clk_q;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    vip_clock_gen_ch #(
      .DIV_W      (DIV_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_en       (ch_en[gi]),
      .i_div_ratio(div_ratio[gi*DIV_W +: DIV_W]),
      .i_div_load (div_load[gi]),
      .o_clk      (w_clk_q[gi]),
      .o_running  (clk_running[gi]),
      .o_cfg_err  (cfg_err[gi])
    );
  end

  // Output enable only; the channels keep counting while passive.
  assign clk_out = agent_is_active ? w_clk_q : {NUM_CH{1'bz}};

endmodule

// File: tb/tb_vip_clock_gen.sv
// Bench for vip_clock_gen: directed scenarios then random traffic against a period-position model.
module tb_vip_clock_gen;

  localparam int NUM_CH      = 2;
  localparam int DIV_W       = 8;
  localparam int DEFAULT_DIV = 2;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic                    agent_is_active = 1'b1;
  logic [NUM_CH-1:0]       ch_en = '0;
  logic [NUM_CH*DIV_W-1:0] div_ratio = '0;
  logic [NUM_CH-1:0]       div_load = '0;
  wire  [NUM_CH-1:0]       clk_out;
  logic [NUM_CH-1:0]       clk_running;
  logic [NUM_CH-1:0]       cfg_err;

  int n_chk = 0;
  int n_err = 0;

  // Model: a channel is either stopped or at position m_p inside a period of length m_n.
  bit m_run   [NUM_CH];
  int m_n     [NUM_CH];
  int m_p     [NUM_CH];
  int m_shadow[NUM_CH];
  bit m_err   [NUM_CH];

  vip_clock_gen #(
    .NUM_CH     (NUM_CH),
    .DIV_W      (DIV_W),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .agent_is_active(agent_is_active),
    .ch_en          (ch_en),
    .div_ratio      (div_ratio),
    .div_load       (div_load),
    .clk_out        (clk_out),
    .clk_running    (clk_running),
    .cfg_err        (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit m_clk(input int ch);
    return m_run[ch] && (m_p[ch] < (m_n[ch] + 1) / 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_run[i]    = 1'b0;
      m_n[i]      = DEFAULT_DIV;
      m_p[i]      = 0;
      m_shadow[i] = DEFAULT_DIV;
      m_err[i]    = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < NUM_CH; i++) begin
      int r;
      r = int'(div_ratio[i*DIV_W +: DIV_W]);
      if (!m_run[i]) begin
        if (ch_en[i]) begin
          m_run[i] = 1'b1;
          m_n[i]   = m_shadow[i];
          m_p[i]   = 0;
        end
      end else begin
        m_p[i]++;
        if (m_p[i] == m_n[i]) begin
          m_n[i] = m_shadow[i];
          m_p[i] = 0;
          if (!ch_en[i]) m_run[i] = 1'b0;
        end
      end
      if (div_load[i]) begin
        if (r < 2) m_err[i] = 1'b1;
        else       m_shadow[i] = r;
      end
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < NUM_CH; i++) begin
      if (agent_is_active) chk_eq($sformatf("clk_out[%0d]", i), 32'(clk_out[i]), 32'(m_clk(i)));
      else                 chk_eq($sformatf("clk_out_passive[%0d]", i), 32'(clk_out[i] === 1'b1), 32'd0);
      chk_eq($sformatf("clk_running[%0d]", i), 32'(clk_running[i]), 32'(m_run[i]));
      chk_eq($sformatf("cfg_err[%0d]", i), 32'(cfg_err[i]), 32'(m_err[i]));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check_outputs();
    div_load = '0;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic load(input int ch, input int ratio);
    div_ratio[ch*DIV_W +: DIV_W] = DIV_W'(ratio);
    div_load[ch] = 1'b1;
  endtask

  task automatic wait_high_start(input int ch);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      cycle();
      if (m_clk(ch) && m_p[ch] == 0) found = 1'b1;
    end
    chk_eq("wait_high_start", 32'(clk_out[ch]), 32'd1);
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    ch_en[0] = 1'b1;
    run(8);

    load(0, 5);
    run(22);

    load(0, 1);
    run(8);

    load(0, 4);
    run(3);
    wait_high_start(0);
    ch_en[0] = 1'b0;
    run(8);

    ch_en = '1;
    run(5);
    agent_is_active = 1'b0;
    run(7);
    agent_is_active = 1'b1;
    run(7);

    wait_high_start(0);
    async_reset();
    run(3);
    ch_en = '0;
    rst_n = 1'b1;
    run(3);
    ch_en[0] = 1'b1;
    run(6);

    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(0, 15) == 0) ch_en[i] = ~ch_en[i];
        if ($urandom_range(0, 9) == 0) load(i, int'($urandom_range(0, 16)));
      end
      if ($urandom_range(0, 39) == 0) agent_is_active = ~agent_is_active;
      if ($urandom_range(0, 599) == 0) begin
        async_reset();
        cycle();
        rst_n = 1'b1;
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/vip_clock_gen.md
Name: vip_clock_gen

Overview:
- Parametrised multi-channel clock generator for the clock VIP.
- Derives NUM_CH output clocks from one reference clock. Each channel has a programmable integer divide ratio, glitch-free start/stop and a shadowed ratio update applied at a period boundary.
- Outputs go high-impedance when the agent is passive, so a passive agent only monitors the clock lines it shares with the DUT.
- Sits between the VIP driver (configuration side) and the DUT clock pins.

Parameters:
- NUM_CH, 2, number of independent output clock channels (1..16).
- DIV_W, 8, width of each divide-ratio field.
- DEFAULT_DIV, 2, active ratio after reset (must be >= 2 and < 2**DIV_W).

Ports:
- clk  input  1  reference clock; every output edge is derived from its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- agent_is_active  input  1  1: drive clk_out; 0: clk_out is 'z.
- ch_en  input  NUM_CH  per-channel run request, level-sensitive.
- div_ratio  input  NUM_CH*DIV_W  per-channel requested ratio; channel i occupies bits [i*DIV_W +: DIV_W].
- div_load  input  NUM_CH  single-cycle pulse; captures div_ratio[i] into the shadow register.
- clk_out  output  NUM_CH  generated clocks; tri-stated when inactive.
- clk_running  output  NUM_CH  1 while the channel is in RUN or STOPPING.
- cfg_err  output  NUM_CH  sticky; set when a load has ratio < 2; cleared only by reset.

Behaviour:
- Reset (async assert, sync release): every channel goes to IDLE.
  - clk_q=0, clk_running=0, cfg_err=0.
  - active ratio = shadow ratio = DEFAULT_DIV.
  - clk_out = 0 if agent_is_active, else 'z.
- Ratio N: high phase = N - (N>>1) clk cycles, low phase = N>>1 clk cycles. Period = N; odd N gives the longer high phase.
- Counter: DIV_W bits, counts phase cycles, never wraps (reloaded at each phase end).
- Per-channel FSM, states IDLE / RUN / STOPPING:
  - IDLE: clk_q=0. On ch_en=1, go to RUN. clk_q rises at the first clk edge after ch_en is sampled (1-cycle latency). The shadow ratio is copied to active at this point.
  - RUN: alternate high/low phases. At the end of each low phase (period boundary), copy shadow to active, then start a new high phase. If ch_en=0 is sampled, go to STOPPING.
  - STOPPING: complete the current period. At the end of the low phase, go to IDLE with clk_q=0. If ch_en returns to 1 before then, go back to RUN with no truncated pulse.
- No runt pulses: high and low phases are never shortened, in any case.
- div_load with ratio >= 2: updates the shadow only. The active ratio changes at the next period boundary or IDLE->RUN transition. The last load before the boundary wins.
- div_load with ratio 0 or 1: shadow unchanged; cfg_err[i] set.
- div_load in the same cycle as a period boundary: the boundary uses the old shadow; the new value applies at the following boundary.
- Mid-operation reset: clk_out drops to 0 immediately and asynchronously. This is the only permitted truncation.
- agent_is_active: affects only the output enable, with no effect on internal state. Toggling it while running resumes the drive with the correct phase.
- Channels are fully independent; identical ratios enabled in the same cycle produce phase-aligned outputs.

Decomposition:
- Package vip_clock_pkg holds:
  - typedef enum {IDLE, RUN, STOPPING} clk_gen_state_e;
  - the constant MIN_DIV = 2;
  - a function for the high-phase length.
- Sub-module vip_clock_gen_ch: one channel (FSM, counter, shadow, err).
- Top level: a generate loop over NUM_CH plus the tri-state assign.

Test Plan:
- Reset then ch_en[0]=1 with DEFAULT_DIV=2 -> clk_out[0] rises 1 cycle after enable, period 2, 50% duty; clk_running[0]=1.
- div_load ratio 5 while running at 2 -> the current period completes, then high 3 / low 2 cycles; no shorter pulse observed.
- ch_en dropped mid-high-phase at N=4 -> the high phase stays 2 cycles and the low phase 2 cycles; then clk_out=0, clk_running=0.
- div_load ratio 1 -> cfg_err=1 and sticky; the ratio stays at its previous value.
- agent_is_active=0 while running -> clk_out='z. Re-assert -> the drive resumes phase-consistent with an uninterrupted count.
- rst_n asserted mid-high-phase -> clk_out=0 with no clock edge; all outputs at reset values; after release the channel is IDLE until ch_en is sampled.
